// File: rtl/f_rec_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : f_rec_pkg                                                       |
// | Purpose  : Shared types, widths, constants and recoding helpers for the    |
// |            IEEE-754 -> 65-bit recoded FP converter (f_rec_encode).         |
// | Contents : recState_t FSM encoding, FP32/FP64 field widths, canonical      |
// |            fp32 qNaN, recodeFp32/recodeFp64 field-packing functions.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package f_rec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } recState_t;

    localparam int c_fp32ExpW  = 8;
    localparam int c_fp32FracW = 23;
    localparam int c_fp32RecW  = 33;
    localparam int c_fp64ExpW  = 11;
    localparam int c_fp64FracW = 52;
    localparam int c_fp64RecW  = 65;

    // Normalisation work register holds an fp64 fraction; fp32 fractions
    // are MSB-aligned into it. Shift count never exceeds 51.
    localparam int c_workW = 52;
    localparam int c_cntW  = 6;

    localparam logic [31:0] c_fp32QNaN = 32'h7FC0_0000;

    // Packs sign/exponent/fraction into the recoded fp64 layout.
    // For a zero-exponent operand the exponent is rebuilt from ~normDist,
    // which places subnormals below the smallest normal exponent.
    function automatic logic [c_fp64RecW-1:0] recodeFp64(
        input logic                   sign,
        input logic [c_fp64ExpW-1:0]  expField,
        input logic                   fracNz,
        input logic [c_fp64FracW-1:0] fract,
        input logic [c_cntW-1:0]      normDist
    );
        logic [c_fp64ExpW:0] adj;
        logic [2:0]          expTop;
        adj = ((expField == '0) ? ~{6'd0, normDist} : {1'b0, expField})
            + ((expField == '0) ? 12'h402 : 12'h401);
        if (adj[11:10] == 2'b11) begin
            expTop = {2'b11, fracNz};
        end else if ((expField == '0) && !fracNz) begin
            expTop = 3'b000;
        end else begin
            expTop = adj[11:9];
        end
        return {sign, expTop, adj[8:0], fract};
    endfunction

    // Same packing for fp32; result is zero-extended to 65 bits.
    function automatic logic [c_fp64RecW-1:0] recodeFp32(
        input logic                   sign,
        input logic [c_fp32ExpW-1:0]  expField,
        input logic                   fracNz,
        input logic [c_fp32FracW-1:0] fract,
        input logic [c_cntW-1:0]      normDist
    );
        logic [c_fp32ExpW:0] adj;
        logic [2:0]          expTop;
        adj = ((expField == '0) ? ~{3'd0, normDist} : {1'b0, expField})
            + ((expField == '0) ? 9'h082 : 9'h081);
        if (adj[8:7] == 2'b11) begin
            expTop = {2'b11, fracNz};
        end else if ((expField == '0) && !fracNz) begin
            expTop = 3'b000;
        end else begin
            expTop = adj[8:6];
        end
        return {32'd0, sign, expTop, adj[5:0], fract};
    endfunction

endpackage
`default_nettype wire

// File: rtl/f_rec_lzc_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : f_rec_lzc_step                                                  |
// | Purpose  : Leading-zero counter over one STEP-bit normalisation window.    |
// | Ports    : i_window   in  STEP          window, MSB first                  |
// |            o_count    out clog2(STEP)+1 leading zeros (STEP if all zero)   |
// |            o_allZero  out 1             window contains no set bit         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module f_rec_lzc_step #(
    parameter int STEP = 4
) (
    input  logic [STEP-1:0]      i_window,
    output logic [$clog2(STEP):0] o_count,
    output logic                 o_allZero
);

    localparam int c_countW = $clog2(STEP) + 1;

    // Scanning upward lets the highest set bit have the final say.
    always_comb begin
        o_count = c_countW'(STEP);
        for (int i = 0; i < STEP; i++) begin
            if (i_window[i]) begin
                o_count = c_countW'(STEP - 1 - i);
            end
        end
    end

    assign o_allZero = (i_window == '0);

endmodule
`default_nettype wire

// File: rtl/f_rec_encode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : f_rec_encode                                                    |
// | Purpose  : Converts IEEE-754 binary32/binary64 operands into the 65-bit    |
// |            recoded FP format. Normal/zero/special operands take one cycle; |
// |            subnormals are normalised STEP bits per cycle.                  |
// | Ports    : clk        in  1   clock                                        |
// |            rst_l      in  1   synchronous active-low reset                 |
// |            flush      in  1   abort in-flight conversion                   |
// |            in_valid   in  1   / in_ready out 1 : input handshake           |
// |            in_fp64    in  1   1 = binary64, 0 = binary32 in in_data[31:0]  |
// |            in_data    in  64  IEEE operand                                 |
// |            out_valid  out 1   / out_ready in 1 : output handshake          |
// |            out_fp64   out 1   format of out_rec                            |
// |            out_rec    out 65  recoded result (fp32: bits [64:33] = 0)      |
// | Params   : STEP (1,2,4,8) normalisation bits examined per cycle            |
// | Options  : F_REC_NAN_BOX_EN - fp32 operands whose upper word is not all    |
// |            ones are replaced by the canonical qNaN (NaN-boxing).           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module f_rec_encode
    import f_rec_pkg::*;
#(
    parameter int STEP = 4
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_fp64,
    input  logic [63:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_fp64,
    output logic [64:0] out_rec
);

    recState_t                r_state;
    recState_t                w_stateNext;
    logic [c_workW-1:0]       r_work;
    logic [c_cntW-1:0]        r_cnt;
    logic                     r_sign;
    logic                     r_opFp64;
    logic                     r_outFp64;
    logic [c_fp64RecW-1:0]    r_outRec;

    logic [63:0]              w_opData;
    logic                     w_accept;
    logic                     w_inSubnormal;
    logic [c_fp64RecW-1:0]    w_inRec;
    logic [c_workW-1:0]       w_inWork;

    logic [$clog2(STEP):0]    w_lzCount;
    logic                     w_windowZero;
    logic [c_workW-2:0]       w_normFrac;
    logic [c_cntW-1:0]        w_normDist;
    logic [c_fp64RecW-1:0]    w_normRec;

    // ------------------------------------------------------------------
    // Operand selection (optional NaN-boxing of fp32 operands)
    // ------------------------------------------------------------------
`ifdef F_REC_NAN_BOX_EN
    always_comb begin
        w_opData = in_data;
        if (!in_fp64 && (in_data[63:32] != 32'hFFFF_FFFF)) begin
            w_opData = {32'hFFFF_FFFF, c_fp32QNaN};
        end
    end
`else
    assign w_opData = in_data;
`endif

    // ------------------------------------------------------------------
    // Single-cycle path. Zero operands also use normDist = 0; only the
    // low exponent bits are affected, which carry no meaning for zero.
    // ------------------------------------------------------------------
    always_comb begin
        w_inRec       = '0;
        w_inSubnormal = 1'b0;
        w_inWork      = '0;
        if (in_fp64) begin
            w_inSubnormal = (w_opData[62:52] == 11'd0) && (w_opData[51:0] != 52'd0);
            w_inWork      = w_opData[51:0];
            w_inRec       = recodeFp64(w_opData[63], w_opData[62:52],
                                       w_opData[51:0] != 52'd0, w_opData[51:0], 6'd0);
        end else begin
            w_inSubnormal = (w_opData[30:23] == 8'd0) && (w_opData[22:0] != 23'd0);
            w_inWork      = {w_opData[22:0], 29'd0};
            w_inRec       = recodeFp32(w_opData[31], w_opData[30:23],
                                       w_opData[22:0] != 23'd0, w_opData[22:0], 6'd0);
        end
    end

    // ------------------------------------------------------------------
    // Iterative normalisation
    // ------------------------------------------------------------------
    f_rec_lzc_step #(
        .STEP (STEP)
    ) u_lzc (
        .i_window  (r_work[c_workW-1 -: STEP]),
        .o_count   (w_lzCount),
        .o_allZero (w_windowZero)
    );

    // Bits below the leading one after the final shift; the leading one
    // itself lands at work[51] and is implicit in the recoded format.
    assign w_normFrac = r_work[c_workW-2:0] << w_lzCount;
    assign w_normDist = r_cnt + c_cntW'(w_lzCount);
    assign w_normRec  = r_opFp64
                      ? recodeFp64(r_sign, 11'd0, 1'b1, {w_normFrac, 1'b0}, w_normDist)
                      : recodeFp32(r_sign, 8'd0, 1'b1, w_normFrac[50:28], w_normDist);

    // ------------------------------------------------------------------
    // Handshake and FSM
    // ------------------------------------------------------------------
    assign in_ready  = (r_state == IDLE) | ((r_state == DONE) & out_ready);
    assign out_valid = (r_state == DONE);
    // An operand offered while flush is high is dropped.
    assign w_accept  = in_valid & in_ready & ~flush;

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_state <= IDLE;
        end else if (flush) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (w_accept) begin
                    w_stateNext = w_inSubnormal ? NORM : DONE;
                end else if ((r_state == DONE) && out_ready) begin
                    w_stateNext = IDLE;
                end
            end
            NORM: begin
                if (!w_windowZero) begin
                    w_stateNext = DONE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_work    <= '0;
            r_cnt     <= '0;
            r_sign    <= 1'b0;
            r_opFp64  <= 1'b0;
            r_outFp64 <= 1'b0;
            r_outRec  <= '0;
        end else if (w_accept) begin
            if (w_inSubnormal) begin
                r_work   <= w_inWork;
                r_cnt    <= '0;
                r_sign   <= in_fp64 ? w_opData[63] : w_opData[31];
                r_opFp64 <= in_fp64;
            end else begin
                r_outRec  <= w_inRec;
                r_outFp64 <= in_fp64;
            end
        end else if ((r_state == NORM) && !flush) begin
            if (w_windowZero) begin
                r_work <= r_work << STEP;
                r_cnt  <= r_cnt + c_cntW'(STEP);
            end else begin
                r_outRec  <= w_normRec;
                r_outFp64 <= r_opFp64;
            end
        end
    end

    assign out_rec  = r_outRec;
    assign out_fp64 = r_outFp64;

endmodule
`default_nettype wire

// File: tb/tb_f_rec_encode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_f_rec_encode                                                 |
// | Purpose  : Self-checking bench for f_rec_encode: directed literal cases    |
// |            plus randomized traffic compared against a transaction-level    |
// |            reference model every cycle.                                    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_f_rec_encode;

    localparam int STEP = 4;

    logic        clk;
    logic        rst_l;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        in_fp64;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_fp64;
    logic [64:0] out_rec;

    int checks = 0;
    int errors = 0;

    f_rec_encode #(
        .STEP (STEP)
    ) dut (
        .clk       (clk),
        .rst_l     (rst_l),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fp64   (in_fp64),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_fp64  (out_fp64),
        .out_rec   (out_rec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: value from the IEEE definition, timing as a
    // per-transaction latency.
    // ------------------------------------------------------------------
    function automatic logic [63:0] boxed(input logic fp64, input logic [63:0] d);
        logic [63:0] r;
        r = d;
`ifdef F_REC_NAN_BOX_EN
        if (!fp64 && (d[63:32] != 32'hFFFF_FFFF)) r = 64'h0000_0000_7FC0_0000;
`endif
        return r;
    endfunction

    // Distance the leading one must move to become the implicit bit,
    // or -1 if the operand is not subnormal.
    function automatic int subDist(input logic fp64, input logic [63:0] d);
        if (fp64) begin
            if (d[62:52] == 11'd0) begin
                for (int i = 51; i >= 0; i--) if (d[i]) return 51 - i;
            end
        end else begin
            if (d[30:23] == 8'd0) begin
                for (int i = 22; i >= 0; i--) if (d[i]) return 22 - i;
            end
        end
        return -1;
    endfunction

    function automatic logic [64:0] modelRec(input logic fp64, input logic [63:0] raw);
        logic [63:0] d, f, expRec, frac;
        int E, F, e, nd;
        logic s;
        d = boxed(fp64, raw);
        if (fp64) begin
            E = 11; F = 52; s = d[63]; e = int'(d[62:52]); f = {12'd0, d[51:0]};
        end else begin
            E = 8;  F = 23; s = d[31]; e = int'(d[30:23]); f = {41'd0, d[22:0]};
        end
        nd   = subDist(fp64, d);
        frac = f;
        if (e == (1 << E) - 1) begin
            expRec = (64'd3 << (E - 1)) | ((f != 0) ? (64'd1 << (E - 2)) : 64'd0);
        end else if (e == 0 && f == 0) begin
            expRec = 64'd1;
        end else if (nd >= 0) begin
            expRec = 64'((1 << (E - 1)) + 1 - nd);
            frac   = (f << (nd + 1)) & ((64'd1 << F) - 1);
        end else begin
            expRec = 64'(e + (1 << (E - 1)) + 1);
        end
        return (65'(s) << (E + 1 + F)) | (65'(expRec) << F) | 65'(frac);
    endfunction

    function automatic int modelLat(input logic fp64, input logic [63:0] raw);
        int nd;
        nd = subDist(fp64, boxed(fp64, raw));
        return (nd < 0) ? 1 : 2 + nd / STEP;
    endfunction

    logic        mHave = 1'b0;
    logic        mFp64 = 1'b0;
    logic [64:0] mRes = '0;
    logic        mPendFp64 = 1'b0;
    logic [64:0] mPendRes = '0;
    int          mRemain = 0;
    int          mLat;
    logic        mRdy;
    bit          started = 1'b0;

    always @(posedge clk) begin
        mRdy = (mRemain == 0) && (!mHave || out_ready);
        if (!rst_l) begin
            mHave = 1'b0; mRemain = 0; started = 1'b1;
        end else if (flush) begin
            mHave = 1'b0; mRemain = 0;
        end else begin
            if (mHave && out_ready) mHave = 1'b0;
            if (mRemain > 0) begin
                mRemain--;
                if (mRemain == 0) begin
                    mHave = 1'b1; mRes = mPendRes; mFp64 = mPendFp64;
                end
            end
            if (in_valid && mRdy) begin
                mLat = modelLat(in_fp64, in_data);
                if (mLat == 1) begin
                    mHave = 1'b1; mRes = modelRec(in_fp64, in_data); mFp64 = in_fp64;
                end else begin
                    mRemain = mLat - 1;
                    mPendRes = modelRec(in_fp64, in_data); mPendFp64 = in_fp64;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", 65'(in_ready), 65'((mRemain == 0) && (!mHave || out_ready)));
            chk("out_valid", 65'(out_valid), 65'(mHave));
            if (mHave) begin
                chk("out_rec", out_rec, mRes);
                chk("out_fp64", 65'(out_fp64), 65'(mFp64));
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic offer(input logic fp64, input logic [63:0] data, input logic rdyOut);
        int n;
        @(posedge clk); #1;
        in_valid = 1'b1; in_fp64 = fp64; in_data = data; out_ready = rdyOut; flush = 1'b0;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL offer_timeout in_ready=%0b required=1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic waitValid(output int lat);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic sendOne(input string name, input logic fp64, input logic [63:0] data,
                           input logic [64:0] expRec, input int expLat);
        int lat;
        offer(fp64, data, 1'b1);
        waitValid(lat);
        chk({name, "_latency"}, 65'(lat), 65'(expLat));
        chk({name, "_rec"}, out_rec, expRec);
        chk({name, "_fp64"}, 65'(out_fp64), 65'(fp64));
    endtask

    function automatic logic [63:0] genOperand(input logic fp64);
        logic [63:0] d;
        int k;
        d = {$urandom, $urandom};
        k = $urandom_range(0, 5);
        if (fp64) begin
            case (k)
                0: d[62:0] = '0;
                1: begin
                    d[62:52] = '0;
                    d[51:0]  = d[51:0] >> $urandom_range(0, 51);
                    if (d[51:0] == '0) d[0] = 1'b1;
                end
                2: d[62:52] = '1;
                3: begin d[62:52] = '1; d[51:0] = '0; end
                default: ;
            endcase
        end else begin
            case (k)
                0: d[30:0] = '0;
                1: begin
                    d[30:23] = '0;
                    d[22:0]  = d[22:0] >> $urandom_range(0, 22);
                    if (d[22:0] == '0) d[0] = 1'b1;
                end
                2: d[30:23] = '1;
                3: begin d[30:23] = '1; d[22:0] = '0; end
                default: ;
            endcase
            if ($urandom_range(0, 7) != 0) d[63:32] = 32'hFFFF_FFFF;
        end
        return d;
    endfunction

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        int  lat;
        bit  seen;
        rst_l = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_fp64 = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", 65'(out_valid), 65'd0);
        chk("reset_out_rec", out_rec, 65'd0);
        chk("reset_out_fp64", 65'(out_fp64), 65'd0);
        chk("reset_in_ready", 65'(in_ready), 65'd1);
        @(posedge clk); #1;
        rst_l = 1'b1; out_ready = 1'b1;

        sendOne("fp32_one", 1'b0, 64'hFFFF_FFFF_3F80_0000, 65'h0_8000_0000, 1);
        sendOne("fp32_min_sub", 1'b0, 64'hFFFF_FFFF_0000_0001, 65'h0_3580_0000, 7);
        sendOne("fp64_inf", 1'b1, 64'h7FF0_0000_0000_0000, 65'h0_C000_0000_0000_0000, 1);
        sendOne("fp64_snan", 1'b1, 64'h7FF0_0000_0000_0001, 65'h0_E000_0000_0000_0001, 1);
        sendOne("fp64_min_sub", 1'b1, 64'h0000_0000_0000_0001, 65'h0_3CE0_0000_0000_0000, 14);
`ifdef F_REC_NAN_BOX_EN
        sendOne("nan_box", 1'b0, 64'h0000_0000_3F80_0000, 65'h0_E040_0000, 1);
`else
        sendOne("nan_box", 1'b0, 64'h0000_0000_3F80_0000, 65'h0_8000_0000, 1);
`endif

        // Backpressure: result held while out_ready is low.
        offer(1'b0, 64'hFFFF_FFFF_3F80_0000, 1'b0);
        waitValid(lat);
        chk("bp_latency", 65'(lat), 65'd1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_rec", out_rec, 65'h0_8000_0000);
            chk("bp_hold_in_ready", 65'(in_ready), 65'd0);
            chk("bp_hold_valid", 65'(out_valid), 65'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b1; in_fp64 = 1'b0; in_data = 64'hFFFF_FFFF_4000_0000;
        @(negedge clk);
        chk("bp_release_in_ready", 65'(in_ready), 65'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_next_valid", 65'(out_valid), 65'd1);
        chk("bp_next_rec", out_rec, 65'h0_8080_0000);

        // Flush during normalisation discards the conversion.
        offer(1'b1, 64'h0000_0000_0000_0001, 1'b1);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 65'(out_valid), 65'd0);
        chk("flush_in_ready", 65'(in_ready), 65'd1);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("flush_no_output", 65'(seen), 65'd0);

        // An operand offered alongside flush is not taken.
        @(posedge clk); #1;
        flush = 1'b1; in_valid = 1'b1; in_fp64 = 1'b1; in_data = 64'h3FF0_0000_0000_0000;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_drop_input", 65'(out_valid), 65'd0);

        // Randomized traffic, checked every cycle by the model.
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            rst_l     = ($urandom_range(0, 199) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            in_valid  = $urandom_range(0, 1);
            out_ready = ($urandom_range(0, 3) != 0);
            in_fp64   = $urandom_range(0, 1);
            in_data   = genOperand(in_fp64);
        end
        @(posedge clk); #1;
        rst_l = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
